// File: rtl/io_conditioner_pkg.sv
// rtl/io_conditioner_pkg.sv - shared types and defaults for the board-input conditioner
// Contents: reset FSM state enum, default parameter values.
package io_cond_pkg;

  typedef enum logic {
    ASSERT = 1'b0,
    IDLE   = 1'b1
  } rst_state_t;

  localparam int DEF_DEBOUNCE_MAX = 50000;
  localparam int DEF_RST_HOLD     = 16;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/io_conditioner_if.sv
// rtl/io_conditioner_if.sv - board-side and cpu-side signals of the input conditioner
// switches_raw/button_raw: raw asynchronous board inputs
// switches/sw_changed/rst_out: conditioned, clock-synchronous outputs
interface io_conditioner_if;

  logic [7:0] switches_raw;
  logic       button_raw;
  logic [7:0] switches;
  logic       sw_changed;
  logic       rst_out;

  // driver side: supplies raw inputs, observes conditioned outputs
  modport master (
    output switches_raw,
    output button_raw,
    input  switches,
    input  sw_changed,
    input  rst_out
  );

  // conditioner side
  modport slave (
    input  switches_raw,
    input  button_raw,
    output switches,
    output sw_changed,
    output rst_out
  );

endinterface

// File: rtl/io_conditioner_debounce_bit.sv
// rtl/io_conditioner_debounce_bit.sv - two-flop synchronizer plus counting debouncer for one bit
// clk, rst   : clock and synchronous active-high reset
// raw        : asynchronous input
// stable     : debounced value (resets to 0)
// changed    : one-cycle pulse in the cycle after stable updates
module debounce_bit #(
  parameter int DEBOUNCE_MAX = 50000,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic changed
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      changed <= 1'b0;
      // any reversion to the stable value throws away the partial count
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_MAX - 1)) begin
        stable  <= s2;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_conditioner.sv
// rtl/io_conditioner.sv - switch debouncer and reset stretcher in front of the cpu
// clk, rst : clock and synchronous active-high power-on/external reset
// bus      : slave side of io_conditioner_if (raw inputs in, conditioned outputs out)
module io_conditioner
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_MAX   = DEF_DEBOUNCE_MAX,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int RST_HOLD       = DEF_RST_HOLD,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  io_conditioner_if.slave   bus
);

  localparam int HW = $clog2(RST_HOLD + 1);

  logic [7:0]  sw_stable;
  logic [7:0]  sw_chg;
  logic        btn_norm;
  logic        btn;
  logic        btn_changed_unused;

  rst_state_t  state;
  logic [HW-1:0] hcnt;
  logic        rst_q;

  for (genvar i = 0; i < 8; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_MAX (DEBOUNCE_MAX),
      .CNT_W        (CNT_W)
    ) u_sw (
      .clk     (clk),
      .rst     (rst),
      .raw     (bus.switches_raw[i]),
      .stable  (sw_stable[i]),
      .changed (sw_chg[i])
    );
  end

  // normalize to pressed = 1 so the debouncer's reset value of 0 means released
  assign btn_norm = BTN_ACTIVE_LOW ? ~bus.button_raw : bus.button_raw;

  debounce_bit #(
    .DEBOUNCE_MAX (DEBOUNCE_MAX),
    .CNT_W        (CNT_W)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .raw     (btn_norm),
    .stable  (btn),
    .changed (btn_changed_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ASSERT;
      hcnt  <= '0;
      rst_q <= 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          rst_q <= 1'b1;
          if (hcnt != HW'(RST_HOLD)) begin
            hcnt <= hcnt + 1'b1;
          end
          // a press on the completing edge keeps us here (btn must be 0 to leave)
          if (hcnt == HW'(RST_HOLD) && !btn) begin
            state <= IDLE;
            rst_q <= 1'b0;
          end
        end
        IDLE: begin
          rst_q <= 1'b0;
          if (btn) begin
            state <= ASSERT;
            hcnt  <= '0;
            rst_q <= 1'b1;
          end
        end
        default: begin
          state <= ASSERT;
          hcnt  <= '0;
          rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.switches   = sw_stable;
  assign bus.sw_changed = |sw_chg;
  assign bus.rst_out    = rst_q;

endmodule

// File: tb/tb_io_conditioner.sv
// tb/tb_io_conditioner.sv - directed self-checking bench for io_conditioner
module tb_io_conditioner;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  io_conditioner_if bus ();

  io_conditioner #(
    .DEBOUNCE_MAX   (4),
    .CNT_W          (4),
    .RST_HOLD       (3),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.switches_raw = 8'h00;
    bus.button_raw   = 1'b1;

    // reset release
    tick();
    tick();
    check("reset_rst_out", {31'd0, bus.rst_out}, 32'd1);
    check("reset_switches", {24'd0, bus.switches}, 32'h00);
    check("reset_sw_changed", {31'd0, bus.sw_changed}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("release_rst_out_e%0d", i), {31'd0, bus.rst_out}, (i < 4) ? 32'd1 : 32'd0);
      check($sformatf("release_switches_e%0d", i), {24'd0, bus.switches}, 32'h00);
    end

    // clean switch change
    bus.switches_raw = 8'hA5;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("clean_switches_e%0d", i), {24'd0, bus.switches}, (i >= 6) ? 32'hA5 : 32'h00);
      check($sformatf("clean_sw_changed_e%0d", i), {31'd0, bus.sw_changed}, (i == 6) ? 32'd1 : 32'd0);
    end
    bus.switches_raw = 8'h00;
    for (int i = 1; i <= 10; i++) tick();
    check("clean_back_to_zero", {24'd0, bus.switches}, 32'h00);
    check("clean_back_sw_changed", {31'd0, bus.sw_changed}, 32'd0);

    // glitch rejection: 3-cycle pulse on bit 0
    bus.switches_raw = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) bus.switches_raw = 8'h00;
      tick();
      check($sformatf("glitch3_switches_e%0d", i), {24'd0, bus.switches}, 32'h00);
      check($sformatf("glitch3_sw_changed_e%0d", i), {31'd0, bus.sw_changed}, 32'd0);
    end

    // 5-cycle pulse is accepted, then the fall is debounced too
    bus.switches_raw = 8'h01;
    for (int i = 1; i <= 12; i++) begin
      if (i == 6) bus.switches_raw = 8'h00;
      tick();
      check($sformatf("pulse5_switches_e%0d", i), {24'd0, bus.switches},
            (i >= 6 && i <= 10) ? 32'h01 : 32'h00);
      check($sformatf("pulse5_sw_changed_e%0d", i), {31'd0, bus.sw_changed},
            (i == 6 || i == 11) ? 32'd1 : 32'd0);
    end

    // bouncing button: raw 0,1,0,1 then held 0; release present before edge 12
    for (int i = 1; i <= 20; i++) begin
      case (i)
        1, 3:    bus.button_raw = 1'b0;
        2, 4:    bus.button_raw = 1'b1;
        5:       bus.button_raw = 1'b0;
        12:      bus.button_raw = 1'b1;
        default: ;
      endcase
      tick();
      check($sformatf("button_rst_out_e%0d", i), {31'd0, bus.rst_out},
            (i >= 11 && i <= 17) ? 32'd1 : 32'd0);
    end

    // reset mid-operation: switch count at 2, FSM idle
    bus.switches_raw = 8'h80;
    for (int i = 1; i <= 12; i++) begin
      rst = (i == 5);
      tick();
      check($sformatf("midrst_rst_out_e%0d", i), {31'd0, bus.rst_out},
            (i >= 5 && i <= 8) ? 32'd1 : 32'd0);
      check($sformatf("midrst_switches_e%0d", i), {24'd0, bus.switches},
            (i >= 11) ? 32'h80 : 32'h00);
      check($sformatf("midrst_sw_changed_e%0d", i), {31'd0, bus.sw_changed},
            (i == 11) ? 32'd1 : 32'd0);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
